// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output cout, overflow, zero, negative
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus
// iterative shifts and shift-add unsigned multiply.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam int M  = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               cout_q;
  logic               ovf_q;
  logic               zero_q;
  logic               neg_q;

  logic               accept;
  logic               multi;
  logic               is_shift;
  logic               is_mul;
  logic               is_sub;
  logic               last;
  logic [SW-1:0]      amt;
  logic [WIDTH-1:0]   bb;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout;
  logic               alu_ovf;
  logic [WIDTH-1:0]   sh_val;
  logic [WIDTH:0]     mul_hi;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0]   res_d;
  logic               cout_d;
  logic               ovf_d;

  assign bus.in_ready  = (state_q == S_IDLE)
                       | ((state_q == S_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign amt      = bus.b[SW-1:0];
  assign is_mul   = (bus.op == OP_MUL);
  assign is_shift = (bus.op == OP_SLL)
                  | (bus.op == OP_SRL)
                  | (bus.op == OP_SRA);
  assign multi    = is_mul | (is_shift & (amt != '0));
  assign is_sub   = (bus.op == OP_SUB);
  assign bb       = is_sub ? ~bus.b : bus.b;
  assign sum      = {1'b0, bus.a} + {1'b0, bb}
                  + {{WIDTH{1'b0}}, is_sub};
  assign last     = (cnt_q == {{(CW-1){1'b0}}, 1'b1});

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        alu_res  = sum[M:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = (bus.a[M] == bb[M])
                 & (sum[M] != bus.a[M]);
      end
      OP_NOT: alu_res = ~bus.a;
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SLT: alu_res = {{M{1'b0}},
                         $signed(bus.a) < $signed(bus.b)};
      OP_EQ:  alu_res = {{M{1'b0}}, bus.a == bus.b};
      // zero-amount shifts pass a straight through
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    sh_val = acc_q[M:0];
    case (op_q)
      OP_SLL:  sh_val = {acc_q[M-1:0], 1'b0};
      OP_SRL:  sh_val = {1'b0, acc_q[M:1]};
      OP_SRA:  sh_val = {acc_q[M], acc_q[M:1]};
      default: sh_val = acc_q[M:0];
    endcase
  end

  // multiplier lives in the low half and retires LSB first
  assign mul_hi  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mcand_q}
                             : {(WIDTH+1){1'b0}});
  assign mul_acc = {mul_hi, acc_q[M:1]};

  always_comb begin
    res_d  = alu_res;
    cout_d = alu_cout;
    ovf_d  = alu_ovf;
    if (state_q == S_EXEC) begin
      cout_d = 1'b0;
      if (op_q == OP_MUL) begin
        res_d = mul_acc[M:0];
        ovf_d = |mul_acc[2*WIDTH-1:WIDTH];
      end else begin
        res_d = sh_val;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        S_EXEC: begin
          cnt_q <= cnt_q - 1'b1;
          acc_q <= (op_q == OP_MUL)
                 ? mul_acc
                 : {acc_q[2*WIDTH-1:WIDTH], sh_val};
          if (last) begin
            state_q <= S_DONE;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= (res_d == '0);
            neg_q   <= res_d[M];
          end
        end
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q <= bus.op;
            if (multi) begin
              state_q <= S_EXEC;
              mcand_q <= bus.a;
              acc_q   <= is_mul
                       ? {{WIDTH{1'b0}}, bus.b}
                       : {{WIDTH{1'b0}}, bus.a};
              cnt_q   <= is_mul
                       ? CW'(WIDTH)
                       : {1'b0, amt};
            end else begin
              state_q <= S_DONE;
              res_q   <= res_d;
              cout_q  <= cout_d;
              ovf_q   <= ovf_d;
              zero_q  <= (res_d == '0);
              neg_q   <= res_d[M];
            end
          end else if (state_q == S_DONE && bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against
// an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    int           lat;
  } exp_t;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint sa   = longint'($signed(a));
    longint sb   = longint'($signed(b));
    longint full = longint'(1) << W;
    longint half = full / 2;
    longint r    = 0;
    longint s;
    int     amt  = int'(ub % W);
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    e.lat  = 1;
    case (op)
      4'd0: begin
        r = ua + ub;
        s = sa + sb;
        e.cout = (r >= full);
        e.ovf  = (s >= half) || (s < -half);
      end
      4'd1: begin
        r = ua + (full - 1 - ub) + 1;
        s = sa - sb;
        e.cout = (r >= full);
        e.ovf  = (s >= half) || (s < -half);
      end
      4'd2: r = (full - 1) - ua;
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: r = (sa < sb) ? 1 : 0;
      4'd7: r = (ua == ub) ? 1 : 0;
      4'd8: r = ua << amt;
      4'd9: r = ua >> amt;
      4'd10: r = sa >>> amt;
      4'd11: begin
        r = ua * ub;
        e.ovf = (r >= full);
        e.lat = 1 + W;
      end
      default: r = 0;
    endcase
    if (op >= 4'd8 && op <= 4'd10 && amt != 0)
      e.lat = 1 + amt;
    r = r & (full - 1);
    e.res = r[W-1:0];
    return e;
  endfunction

  // Caller is #1 after a posedge with the DUT idle.
  task automatic run_op(input logic [3:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input int hold,
                        input string tag);
    exp_t e;
    int   edges;
    logic [W+3:0] want;
    e = model(op, a, b);
    edges = 0;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    want = {e.ovf, e.cout, (e.res == '0), e.res[W-1], e.res};
    check({tag, ".latency"}, 64'(edges), 64'(e.lat - 1));
    check({tag, ".result"}, 64'(bus.result), 64'(e.res));
    check({tag, ".flags"},
          64'({bus.overflow, bus.cout, bus.zero, bus.negative}),
          64'(want[W+3:W]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold"},
            64'({bus.out_valid, bus.in_ready, bus.overflow,
                 bus.cout, bus.zero, bus.negative, bus.result}),
            64'({2'b10, want}));
    end
    bus.out_ready = 1'b1;
    #1;
    check({tag, ".rdy_release"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".drained"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    exp_t e;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    check("reset.outs",
          64'({bus.out_valid, bus.in_ready, bus.overflow,
               bus.cout, bus.zero, bus.negative, bus.result}),
          64'({2'b01, 4'b0000, 8'h00}));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(4'd0,  8'h7F, 8'h01, 0, "add_ovf");
    run_op(4'd1,  8'h05, 8'h05, 0, "sub_zero");
    run_op(4'd6,  8'hFF, 8'h01, 0, "slt");
    run_op(4'd7,  8'h3C, 8'h3C, 0, "eq");
    run_op(4'd10, 8'h80, 8'h03, 0, "sra3");
    run_op(4'd9,  8'hA5, 8'h08, 0, "srl_amt0");
    run_op(4'd11, 8'h10, 8'h11, 5, "mul_hold");
    run_op(4'd13, 8'h12, 8'h34, 1, "undef");
    run_op(4'd8,  8'h81, 8'h0F, 0, "sll7");
    run_op(4'd11, 8'hFF, 8'hFF, 0, "mul_max");

    // back-to-back logic stream, one result per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(3, 5));
      a  = W'($urandom);
      b  = W'($urandom);
      e  = model(op, a, b);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      @(posedge clk);
      #1;
      check($sformatf("stream%0d", i),
            64'({bus.out_valid, bus.in_ready, bus.result}),
            64'({2'b11, e.res}));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream.end", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom),
             W'($urandom), int'($urandom_range(0, 2)),
             $sformatf("rnd%0d", i));
    end

    // reset during the 4th execute cycle of a multiply
    bus.in_valid = 1'b1;
    bus.op       = 4'd11;
    bus.a        = 8'h10;
    bus.b        = 8'h11;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.outs",
          64'({bus.out_valid, bus.in_ready, bus.overflow,
               bus.cout, bus.zero, bus.negative, bus.result}),
          64'({2'b01, 4'b0000, 8'h00}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(4'd0, 8'h01, 8'h01, 0, "add_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
